// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU types and helpers; LSU_MISALIGN_EN enables split accesses.
package lsu_pkg;

  typedef logic [7:0]  u8_t;
  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC1,
    ST_ACC2,
    ST_RESP
  } lsu_state_t;

  typedef struct packed {
    logic      we;
    lsu_size_t size;
    logic      sgn;
    u32_t      addr;
    u32_t      wdata;
  } lsu_req_t;

`ifdef LSU_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  // True when the access crosses a word boundary.
  function automatic logic is_misaligned(lsu_size_t size, logic [1:0] off);
    return ((size == SZ_HALF) && (off == 2'd3)) || ((size == SZ_WORD) && (off != 2'd0));
  endfunction

  function automatic wrstb_t size_mask(lsu_size_t size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response handshake bundle between a requester and the LSU.
interface lsu_if
  import lsu_pkg::*;
();

  logic      req_valid;
  logic      req_ready;
  logic      req_we;
  lsu_size_t req_size;
  logic      req_signed;
  u32_t      req_addr;
  u32_t      req_wdata;
  logic      rsp_valid;
  u32_t      rsp_rdata;
  logic      rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane shifter: store data/strobes per word and load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t  size_i,
  input  logic [1:0] off_i,
  input  logic       signed_i,
  input  logic       hi_lane_i,
  input  u32_t       wdata_i,
  input  u32_t       lo_word_i,
  input  u32_t       hi_word_i,
  output u32_t       wdata_o,
  output wrstb_t     strb_o,
  output u32_t       ldata_o
);

  logic [4:0]  sh;
  logic [63:0] st_wide;
  logic [7:0]  strb_wide;
  logic [63:0] ld_pair;
  u32_t        raw;
  u8_t         ld_byte;

  assign sh = {off_i, 3'b000};

  // Both halves of a split store come from one 64-bit shift; upper half feeds the second word.
  assign st_wide   = {32'd0, wdata_i} << sh;
  assign strb_wide = {4'd0, size_mask(size_i)} << off_i;
  assign wdata_o   = hi_lane_i ? st_wide[63:32]   : st_wide[31:0];
  assign strb_o    = hi_lane_i ? strb_wide[7:4]   : strb_wide[3:0];

  assign ld_pair = {hi_word_i, lo_word_i};
  assign raw     = 32'(ld_pair >> sh);
  assign ld_byte = raw[7:0];

  always_comb begin
    ldata_o = raw;
    case (size_i)
      SZ_BYTE: ldata_o = signed_i ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      SZ_HALF: ldata_o = signed_i ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: ldata_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit, one request at a time; LSU_MISALIGN_EN splits word-crossing accesses.
module lsu
  import lsu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  lsu_if.slave   bus,
  output u32_t   mem_addr,
  output u32_t   mem_wrdata,
  output wrstb_t mem_wrstb,
  input  u32_t   mem_rddata
);

  lsu_state_t state_q;
  lsu_req_t   req_q;
  u32_t       rd_lo_q;
  u32_t       rsp_rdata_q;
  logic       rsp_valid_q;
  logic       rsp_err_q;

  lsu_req_t   req_in;
  logic       req_bad;
  logic       in_acc2;
  u32_t       lo_word;
  u32_t       al_wdata;
  wrstb_t     al_strb;
  u32_t       al_ldata;

  assign req_in = '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                    addr: bus.req_addr, wdata: bus.req_wdata};
  assign req_bad = (bus.req_size == SZ_RSVD) ||
                   (!SPLIT_EN && is_misaligned(bus.req_size, bus.req_addr[1:0]));
  assign in_acc2 = SPLIT_EN && (state_q == ST_ACC2);
  // In ACC2 the first word comes from the capture register, the second straight from memory.
  assign lo_word = (state_q == ST_ACC1) ? mem_rddata : rd_lo_q;

  lsu_align u_align (
    .size_i   (req_q.size),
    .off_i    (req_q.addr[1:0]),
    .signed_i (req_q.sgn),
    .hi_lane_i(in_acc2),
    .wdata_i  (req_q.wdata),
    .lo_word_i(lo_word),
    .hi_word_i(mem_rddata),
    .wdata_o  (al_wdata),
    .strb_o   (al_strb),
    .ldata_o  (al_ldata)
  );

  always_comb begin
    mem_addr   = '0;
    mem_wrdata = '0;
    mem_wrstb  = '0;
    if (rst_n && ((state_q == ST_ACC1) || in_acc2)) begin
      mem_addr   = {req_q.addr[31:2], 2'b00} + (in_acc2 ? 32'd4 : 32'd0);
      mem_wrdata = al_wdata;
      mem_wrstb  = req_q.we ? al_strb : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rd_lo_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_q <= req_in;
            if (req_bad) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ST_ACC1;
            end
          end
        end
        ST_ACC1: begin
          rd_lo_q <= mem_rddata;
          if (SPLIT_EN && is_misaligned(req_q.size, req_q.addr[1:0])) begin
            state_q <= ST_ACC2;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= req_q.we ? 32'd0 : al_ldata;
          end
        end
`ifdef LSU_MISALIGN_EN
        ST_ACC2: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= req_q.we ? 32'd0 : al_ldata;
        end
`endif
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = rst_n && (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have ports: clk  input  1  clock; reset rst_n, synchronous, active-low.
REQ-002 SHALL have: rst_n  input  1  synchronous active-low reset.
REQ-003 SHALL have: req_valid  input  1  request present; req_ready  output  1  request accepted when both high at posedge.
REQ-004 SHALL have: req_we  input  1  store=1/load=0; req_size  input  2  lsu_size_t (00 byte, 01 half, 10 word, 11 reserved); req_signed  input  1  sign-extend loads.
REQ-005 SHALL have: req_addr  input  32  byte address; req_wdata  input  32  store data, right-aligned.
REQ-006 SHALL have: rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  32  load result; rsp_err  output  1  request rejected.
REQ-007 SHALL have: mem_addr  output  32  u32_t; mem_wrdata  output  32  u32_t; mem_wrstb  output  4  wrstb_t; mem_rddata  input  32  u32_t, combinational read of word at mem_addr; write commits at posedge.

Function
REQ-008 SHALL implement FSM states IDLE, ACC1, ACC2, RESP; req_ready = (state==IDLE).
REQ-009 On accept, SHALL register request, go to ACC1; no new request accepted until return to IDLE.
REQ-010 ACC1: mem_addr = {addr[31:2],2'b00}; mem_wrdata = wdata shifted left by 8*addr[1:0]; mem_wrstb = (size mask << addr[1:0]) truncated to 4 bits, only if store; load bytes captured at ACC1 end.
REQ-011 Access misaligned when half with addr[1:0]=3 or word with addr[1:0]!=0; aligned accesses go ACC1 -> RESP.
REQ-012 Misaligned (feature enabled): ACC1 -> ACC2; ACC2 mem_addr = first word + 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); mem_wrstb = remaining low lanes; mem_wrdata = wdata shifted right by 8*(4-addr[1:0]).
REQ-013 RESP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_ready absent, consumer must take it.
REQ-014 Load result: bytes assembled in address order; byte/half zero-extended if req_signed=0, sign-extended from bit 7/15 otherwise; word unaffected by req_signed.
REQ-015 Stores: rsp_rdata=0 at RESP.
REQ-016 req_size=11: no memory access (mem_wrstb=0 throughout), ACC1 skipped, RESP with rsp_err=1, rsp_rdata=0.
REQ-017 mem_wrstb SHALL be 0 in IDLE, RESP, and in any state for loads.
REQ-018 Latency: aligned rsp_valid 2 cycles after accept edge; split 3 cycles; error 1 cycle.
REQ-019 rsp_err=0 except REQ-016/REQ-023 cases; rsp_rdata/rsp_err only meaningful while rsp_valid=1.

Reset
REQ-020 rst_n low at posedge SHALL force IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, captured data=0.
REQ-021 While rst_n low: req_ready=0, mem_wrstb=0, mem_addr=0, mem_wrdata=0.
REQ-022 Reset mid-ACC2 SHALL abandon request: ACC1 half may be committed, no further write, no response.

Configuration
REQ-023 Macro LSU_MISALIGN_EN defined: split as REQ-012; undefined: misaligned request skips ACC1, no write, RESP with rsp_err=1, ACC2 unreachable and unsynthesised.

Structure
REQ-024 Package types SHALL gain lsu_size_t enum and lsu_state_t enum; existing u8_t, u32_t, wrstb_t reused.
REQ-025 Sub-module lsu_align (combinational): lane shift, strobe generation, load extraction/sign extension.

Verification
REQ-026 Store word 0xDEADBEEF @0x10 -> ACC1 mem_wrstb=1111, mem_wrdata=0xDEADBEEF; rsp_valid 2 cycles post-accept, rsp_err=0.
REQ-027 Store byte 0xA5 @0x13, then signed load byte @0x13 -> wrstb=1000, wrdata=0xA5000000; load rsp_rdata=0xFFFFFFA5; unsigned load =0x000000A5.
REQ-028 LSU_MISALIGN_EN: store word 0x11223344 @0x06 -> ACC1 addr 0x04 wrstb=1100 wrdata=0x33440000; ACC2 addr 0x08 wrstb=0011 wrdata=0x00001122; load word @0x06 -> 0x11223344, latency 3.
REQ-029 Without LSU_MISALIGN_EN: store half @0x03 -> mem_wrstb never nonzero, rsp_err=1 one cycle after accept.
REQ-030 Reserved size 11, then assert rst_n=0 during ACC2 of split store @0xFFFFFFFE -> rsp_err=1 for first; reset: no ACC2 write at 0x00000000, no rsp_valid, req_ready=1 after release.
REQ-031 req_valid held high back-to-back -> req_ready low ACC1..RESP; second request accepted in first IDLE cycle after RESP.
